// File: rtl/bomb_module.sv
// rtl/bomb_module.sv - single-bomb controller: placement, fuse/explosion timing, blocking and pixel flags
module bomb_module #(
   parameter int FUSE_CYCLES = 200_000_000,
   parameter int EXP_CYCLES  = 50_000_000,
   parameter int EXP_RANGE   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic [9:0] x_b,
   input  logic [9:0] y_b,
   input  logic [1:0] cd,
   input  logic       place,
   input  logic       gameover,
   output logic       bm_blocked,
   output logic       bomb_active,
   output logic       exploding,
   output logic       exp_done,
   output logic [5:0] bomb_col,
   output logic [4:0] bomb_row,
   output logic       bomb_on,
   output logic       exp_on,
   output logic [7:0] bomb_addr
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      EXPLODE = 2'd2
   } state_t;

   localparam logic [27:0] FUSE_LAST = 28'(FUSE_CYCLES - 1);
   localparam logic [27:0] EXP_LAST  = 28'(EXP_CYCLES - 1);
   localparam logic [6:0]  RANGE     = 7'(EXP_RANGE);

   state_t      state_q, state_d;
   logic [27:0] timer_q, timer_d;
   logic [5:0]  col_q, col_d;
   logic [4:0]  row_q, row_d;
   logic [6:0]  arm_l_q, arm_l_d, arm_r_q, arm_r_d;
   logic [6:0]  arm_u_q, arm_u_d, arm_d_q, arm_d_d;
   logic        place_prev_q, place_prev_d;
   logic        bomb_active_q, bomb_active_d;
   logic        exploding_q, exploding_d;
   logic        exp_done_q, exp_done_d;

   logic        req;
   logic [9:0]  col_diff, row_diff;
   logic [5:0]  new_col, new_row;
   logic [6:0]  new_arm_l, new_arm_r, new_arm_u, new_arm_d;

   function automatic logic [6:0] clamp_range(input logic [6:0] v);
      return (v < RANGE) ? v : RANGE;
   endfunction

   function automatic logic overlap(input logic signed [12:0] ax, input logic signed [12:0] ay,
                                    input logic signed [12:0] tx, input logic signed [12:0] ty);
      return (ax <= tx + 13'sd15) && (ax + 13'sd15 >= tx) &&
             (ay <= ty + 13'sd15) && (ay + 13'sd15 >= ty);
   endfunction

   // Tile under the hitbox centre and the explosion arms it would get, clipped to arena and pillars
   always_comb begin
      col_diff  = x_b - 10'd40;
      row_diff  = y_b - 10'd15;
      new_col   = col_diff[9:4];
      new_row   = row_diff[9:4];
      new_arm_l = new_row[0] ? 7'd0 : clamp_range({1'b0, new_col});
      new_arm_r = new_row[0] ? 7'd0 : clamp_range(7'd32 - {1'b0, new_col});
      new_arm_u = new_col[0] ? 7'd0 : clamp_range({1'b0, new_row});
      new_arm_d = new_col[0] ? 7'd0 : clamp_range(7'd25 - {1'b0, new_row});
   end

   // Next-state logic: place edge detect, fuse/explosion sequencing, shared timer
   always_comb begin
      req           = place & ~place_prev_q & ~gameover & (state_q == IDLE);
      state_d       = state_q;
      timer_d       = timer_q + 28'd1;
      col_d         = col_q;
      row_d         = row_q;
      arm_l_d       = arm_l_q;
      arm_r_d       = arm_r_q;
      arm_u_d       = arm_u_q;
      arm_d_d       = arm_d_q;
      exp_done_d    = 1'b0;
      place_prev_d  = place;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = ARMED;
               col_d   = new_col;
               row_d   = new_row[4:0];
               arm_l_d = new_arm_l;
               arm_r_d = new_arm_r;
               arm_u_d = new_arm_u;
               arm_d_d = new_arm_d;
            end
         end
         ARMED: begin
            if (timer_q == FUSE_LAST) state_d = EXPLODE;
         end
         EXPLODE: begin
            if (timer_q == EXP_LAST) begin
               state_d    = IDLE;
               exp_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) timer_d = '0;
      bomb_active_d = (state_d == ARMED);
      exploding_d   = (state_d == EXPLODE);
   end

   // State, timer, latched tile and registered status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         col_q         <= '0;
         row_q         <= '0;
         arm_l_q       <= '0;
         arm_r_q       <= '0;
         arm_u_q       <= '0;
         arm_d_q       <= '0;
         place_prev_q  <= 1'b0;
         bomb_active_q <= 1'b0;
         exploding_q   <= 1'b0;
         exp_done_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         col_q         <= col_d;
         row_q         <= row_d;
         arm_l_q       <= arm_l_d;
         arm_r_q       <= arm_r_d;
         arm_u_q       <= arm_u_d;
         arm_d_q       <= arm_d_d;
         place_prev_q  <= place_prev_d;
         bomb_active_q <= bomb_active_d;
         exploding_q   <= exploding_d;
         exp_done_q    <= exp_done_d;
      end
   end

   assign bomb_active = bomb_active_q;
   assign exploding   = exploding_q;
   assign exp_done    = exp_done_q;
   assign bomb_col    = col_q;
   assign bomb_row    = row_q;

   logic [10:0] tile_x, tile_y, dx, dy;

   // Bomb sprite hit test; the ROM address is forced to zero off the sprite
   always_comb begin
      tile_x    = 11'd48 + {1'b0, col_q, 4'b0000};
      tile_y    = 11'd32 + {2'b00, row_q, 4'b0000};
      dx        = {1'b0, x} - tile_x;
      dy        = {1'b0, y} - tile_y;
      bomb_on   = (state_q == ARMED) &&
                  ({1'b0, x} >= tile_x) && (dx < 11'd16) &&
                  ({1'b0, y} >= tile_y) && (dy < 11'd16);
      bomb_addr = bomb_on ? {dy[3:0], dx[3:0]} : 8'd0;
   end

   logic signed [12:0] hx, hy, sx, sy, tx_s, ty_s;

   // Block a step only when it newly enters the tile, so the player can walk off a fresh bomb
   always_comb begin
      hx   = $signed({3'b000, x_b});
      hy   = $signed({3'b000, y_b}) + 13'sd9;
      sx   = hx;
      sy   = hy;
      case (cd)
         2'd0:    sy = hy - 13'sd1;
         2'd1:    sx = hx + 13'sd1;
         2'd2:    sy = hy + 13'sd1;
         default: sx = hx - 13'sd1;
      endcase
      tx_s = $signed({2'b00, tile_x});
      ty_s = $signed({2'b00, tile_y});
      bm_blocked = (state_q == ARMED) && overlap(sx, sy, tx_s, ty_s) && !overlap(hx, hy, tx_s, ty_s);
   end

   logic [9:0] px_off, py_off;
   logic [7:0] col_p, row_p, col_c, row_c;
   logic       in_arena, on_row, on_col;

   // Explosion cross: pixel tile on the bomb row within the horizontal arms, or on the bomb column within the vertical arms
   always_comb begin
      px_off   = x - 10'd48;
      py_off   = y - 10'd32;
      col_p    = {2'b00, px_off[9:4]};
      row_p    = {2'b00, py_off[9:4]};
      col_c    = {2'b00, col_q};
      row_c    = {3'b000, row_q};
      in_arena = (x >= 10'd48) && (y >= 10'd32);
      on_row   = (row_p == row_c) && (col_p + {1'b0, arm_l_q} >= col_c) &&
                 (col_p <= col_c + {1'b0, arm_r_q});
      on_col   = (col_p == col_c) && (row_p + {1'b0, arm_u_q} >= row_c) &&
                 (row_p <= row_c + {1'b0, arm_d_q});
      exp_on   = (state_q == EXPLODE) && in_arena && (on_row || on_col);
   end

endmodule
